// File: rtl/dcache_port_arbiter_if.sv
// Signal bundle between the two dcache requesters, the arbiter and the dcache port.
// The arbiter connects through the slave modport; requesters and dcache use master.
interface dcache_port_arbiter_if;
    logic [31:0] r0_addr;
    logic [3:0]  r0_rmask;
    logic [3:0]  r0_wmask;
    logic [31:0] r0_wdata;
    logic [31:0] r0_rdata;
    logic        r0_resp;

    logic [31:0] r1_addr;
    logic [3:0]  r1_rmask;
    logic [3:0]  r1_wmask;
    logic [31:0] r1_wdata;
    logic [31:0] r1_rdata;
    logic        r1_resp;

    logic [31:0] d_addr;
    logic [3:0]  d_rmask;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_resp;

    modport slave (
        input  r0_addr, r0_rmask, r0_wmask, r0_wdata,
        output r0_rdata, r0_resp,
        input  r1_addr, r1_rmask, r1_wmask, r1_wdata,
        output r1_rdata, r1_resp,
        output d_addr, d_rmask, d_wmask, d_wdata,
        input  d_rdata, d_resp
    );

    modport master (
        output r0_addr, r0_rmask, r0_wmask, r0_wdata,
        input  r0_rdata, r0_resp,
        output r1_addr, r1_rmask, r1_wmask, r1_wdata,
        input  r1_rdata, r1_resp,
        input  d_addr, d_rmask, d_wmask, d_wdata,
        output d_rdata, d_resp
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one dcache port between two requesters, with flush drop and watchdog.
// Optional: define DCACHE_ARB_STORE_PRIO_EN to let a write beat a read on a simultaneous request.
module dcache_port_arbiter #(
    parameter int unsigned WATCHDOG_MAX = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    dcache_port_arbiter_if.slave  bus,
    output logic                  busy,
    output logic                  err_timeout
);
    localparam int unsigned WD_W = $clog2(WATCHDOG_MAX + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_MAX);

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t          state_q, state_d;
    logic            rr_last_q, rr_last_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            drop_q, drop_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      rmask_q, rmask_d;
    logic [3:0]      wmask_q, wmask_d;

    logic req0, req1, pick;
    logic in_busy, rd_txn, drop_now, resp_ok;

    assign req0 = (|bus.r0_rmask) | (|bus.r0_wmask);
    assign req1 = (|bus.r1_rmask) | (|bus.r1_wmask);

    always_comb begin
        pick = req1;
        if (req0 && req1) begin
`ifdef DCACHE_ARB_STORE_PRIO_EN
            if ((|bus.r0_wmask) != (|bus.r1_wmask)) begin
                pick = |bus.r1_wmask;
            end else begin
                pick = ~rr_last_q;
            end
`else
            pick = ~rr_last_q;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        wd_d      = wd_q;
        err_d     = err_q;
        drop_d    = drop_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rmask_d   = rmask_q;
        wmask_d   = wmask_q;
        case (state_q)
            IDLE: begin
                wd_d   = '0;
                drop_d = 1'b0;
                if (req0 || req1) begin
                    rr_last_d = pick;
                    // A request carrying both masks is a write; the read half is discarded.
                    if (pick) begin
                        state_d = BUSY1;
                        addr_d  = {bus.r1_addr[31:2], 2'b00};
                        wmask_d = bus.r1_wmask;
                        rmask_d = (|bus.r1_wmask) ? 4'h0 : bus.r1_rmask;
                        wdata_d = bus.r1_wdata;
                    end else begin
                        state_d = BUSY0;
                        addr_d  = {bus.r0_addr[31:2], 2'b00};
                        wmask_d = bus.r0_wmask;
                        rmask_d = (|bus.r0_wmask) ? 4'h0 : bus.r0_rmask;
                        wdata_d = bus.r0_wdata;
                    end
                end
            end
            BUSY0, BUSY1: begin
                if (wd_q != WD_LIMIT) wd_d = wd_q + WD_W'(1);
                if (wd_d == WD_LIMIT) err_d = 1'b1;
                if (flush && rd_txn) drop_d = 1'b1;
                if (bus.d_resp) begin
                    state_d = IDLE;
                    wd_d    = '0;
                    drop_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            wd_q      <= '0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rmask_q   <= '0;
            wmask_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            wd_q      <= wd_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rmask_q   <= rmask_d;
            wmask_q   <= wmask_d;
        end
    end

    assign in_busy  = (state_q != IDLE);
    assign rd_txn   = (wmask_q == 4'h0);
    // A flush on the response cycle itself must also squash a load response.
    assign drop_now = rd_txn && (drop_q || flush);
    assign resp_ok  = in_busy && bus.d_resp && !drop_now;

    assign bus.r0_resp  = resp_ok && (state_q == BUSY0);
    assign bus.r1_resp  = resp_ok && (state_q == BUSY1);
    assign bus.r0_rdata = (bus.r0_resp && rd_txn) ? bus.d_rdata : 32'h0;
    assign bus.r1_rdata = (bus.r1_resp && rd_txn) ? bus.d_rdata : 32'h0;

    assign bus.d_addr  = in_busy ? addr_q  : 32'h0;
    assign bus.d_rmask = in_busy ? rmask_q : 4'h0;
    assign bus.d_wmask = in_busy ? wmask_q : 4'h0;
    assign bus.d_wdata = in_busy ? wdata_q : 32'h0;

    assign busy        = in_busy;
    assign err_timeout = err_q;
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: expected dcache requests/responses are queued
// when requests are driven and compared as the dcache model serves each transaction.
module tb_dcache_port_arbiter;
    localparam int WD = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic busy, err_timeout;

    dcache_port_arbiter_if bus();

    dcache_port_arbiter #(.WATCHDOG_MAX(WD)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic        resp;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_wait = 0;
    logic err_m = 1'b0;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic drive(int p, logic [31:0] a, logic [3:0] rm, logic [3:0] wm, logic [31:0] wd);
        if (p == 0) begin
            bus.r0_addr = a; bus.r0_rmask = rm; bus.r0_wmask = wm; bus.r0_wdata = wd;
        end else begin
            bus.r1_addr = a; bus.r1_rmask = rm; bus.r1_wmask = wm; bus.r1_wdata = wd;
        end
    endtask

    task automatic push(int p, logic [31:0] a, logic [3:0] rm, logic [3:0] wm, logic [31:0] wd,
                        logic drop);
        exp_t e;
        e.port  = (p != 0);
        e.addr  = a & 32'hFFFF_FFFC;
        e.wmask = wm;
        e.rmask = (wm != 4'h0) ? 4'h0 : rm;
        e.wdata = wd;
        e.resp  = !(drop && (wm == 4'h0));
        exp_q.push_back(e);
    endtask

    // Dcache model: waits for the request, checks it each cycle, answers after lat cycles.
    task automatic serve(int lat, logic [31:0] rd, int fcyc, logic [1:0] clr);
        exp_t        e;
        int          w = 0;
        logic [31:0] erd;
        @(negedge clk);
        while (bus.d_rmask == 4'h0 && bus.d_wmask == 4'h0 && w < 12) begin
            @(negedge clk);
            w++;
        end
        last_wait = w;
        if (w >= 12) begin
            chk("dreq_wait", 32'(w), 32'd0);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        erd = (e.resp && e.wmask == 4'h0) ? rd : 32'h0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clk);
            if (c - 1 >= WD) err_m = 1'b1;
            chk("d_addr", bus.d_addr, e.addr);
            chk("d_rmask", 32'(bus.d_rmask), 32'(e.rmask));
            chk("d_wmask", 32'(bus.d_wmask), 32'(e.wmask));
            chk("d_wdata", bus.d_wdata, e.wdata);
            chk("busy", 32'(busy), 32'd1);
            chk("err_timeout", 32'(err_timeout), 32'(err_m));
            flush = (c == fcyc);
            bus.d_resp  = (c == lat);
            bus.d_rdata = (c == lat) ? rd : 32'hA5A5_A5A5;
            #1;
            chk("r0_resp", 32'(bus.r0_resp), 32'(c == lat && e.resp && !e.port));
            chk("r1_resp", 32'(bus.r1_resp), 32'(c == lat && e.resp && e.port));
            chk("r0_rdata", bus.r0_rdata, (c == lat && !e.port) ? erd : 32'h0);
            chk("r1_rdata", bus.r1_rdata, (c == lat && e.port) ? erd : 32'h0);
        end
        @(negedge clk);
        bus.d_resp  = 1'b0;
        bus.d_rdata = 32'h0;
        flush       = 1'b0;
        if (clr[0]) drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
        if (clr[1]) drive(1, 32'h0, 4'h0, 4'h0, 32'h0);
        #1;
        chk("busy_after_resp", 32'(busy), 32'd0);
        chk("d_rmask_idle", 32'(bus.d_rmask), 32'd0);
        chk("r0_resp_idle", 32'(bus.r0_resp), 32'd0);
        chk("r1_resp_idle", 32'(bus.r1_resp), 32'd0);
        chk("err_after_resp", 32'(err_timeout), 32'(err_m));
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err_timeout), 32'd0);
        chk({tag, "_d_addr"}, bus.d_addr, 32'h0);
        chk({tag, "_d_rmask"}, 32'(bus.d_rmask), 32'd0);
        chk({tag, "_d_wmask"}, 32'(bus.d_wmask), 32'd0);
        chk({tag, "_d_wdata"}, bus.d_wdata, 32'h0);
        chk({tag, "_r0_resp"}, 32'(bus.r0_resp), 32'd0);
        chk({tag, "_r1_resp"}, 32'(bus.r1_resp), 32'd0);
        chk({tag, "_r0_rdata"}, bus.r0_rdata, 32'h0);
        chk({tag, "_r1_rdata"}, bus.r1_rdata, 32'h0);
    endtask

    initial begin
        drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
        drive(1, 32'h0, 4'h0, 4'h0, 32'h0);
        bus.d_resp  = 1'b0;
        bus.d_rdata = 32'h0;
        #2 rst = 1'b1;
        #1 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Both ports read continuously from reset: 0,1,0,1 with one idle cycle between.
        drive(0, 32'h0000_2001, 4'hF, 4'h0, 32'h0);
        drive(1, 32'h0000_3002, 4'h3, 4'h0, 32'h0);
        push(0, 32'h0000_2001, 4'hF, 4'h0, 32'h0, 1'b0);
        push(1, 32'h0000_3002, 4'h3, 4'h0, 32'h0, 1'b0);
        push(0, 32'h0000_2001, 4'hF, 4'h0, 32'h0, 1'b0);
        push(1, 32'h0000_3002, 4'h3, 4'h0, 32'h0, 1'b0);
        serve(1, 32'h0000_0A00, 0, 2'b00); chk("bubble0", 32'(last_wait), 32'd0);
        serve(2, 32'h0000_0B01, 0, 2'b00); chk("bubble1", 32'(last_wait), 32'd0);
        serve(1, 32'h0000_0A02, 0, 2'b00); chk("bubble2", 32'(last_wait), 32'd0);
        serve(2, 32'h0000_0B03, 0, 2'b11); chk("bubble3", 32'(last_wait), 32'd0);

        // Port 0 read against port 1 write, rr_last = 1.
        drive(0, 32'h0000_8000, 4'hF, 4'h0, 32'h0);
        drive(1, 32'h0000_9000, 4'h0, 4'hF, 32'h1234_5678);
`ifdef DCACHE_ARB_STORE_PRIO_EN
        push(1, 32'h0000_9000, 4'h0, 4'hF, 32'h1234_5678, 1'b0);
        push(0, 32'h0000_8000, 4'hF, 4'h0, 32'h0, 1'b0);
        serve(1, 32'h7777_0000, 0, 2'b10);
        serve(2, 32'h8888_0000, 0, 2'b01);
`else
        push(0, 32'h0000_8000, 4'hF, 4'h0, 32'h0, 1'b0);
        push(1, 32'h0000_9000, 4'h0, 4'hF, 32'h1234_5678, 1'b0);
        serve(1, 32'h8888_0000, 0, 2'b01);
        serve(2, 32'h7777_0000, 0, 2'b10);
`endif

        // Single port 0 read with an unaligned address and three-cycle dcache latency.
        drive(0, 32'h0000_1003, 4'b0001, 4'h0, 32'h0);
        push(0, 32'h0000_1003, 4'b0001, 4'h0, 32'h0, 1'b0);
        serve(3, 32'hDEAD_BEEF, 0, 2'b01);

        // Flush during a port 1 read drops its response; a write is never dropped.
        drive(1, 32'h0000_6004, 4'b0011, 4'h0, 32'h0);
        push(1, 32'h0000_6004, 4'b0011, 4'h0, 32'h0, 1'b1);
        serve(3, 32'h1111_2222, 1, 2'b10);
        drive(1, 32'h0000_700B, 4'hF, 4'b1100, 32'h55AA_55AA);
        push(1, 32'h0000_700B, 4'hF, 4'b1100, 32'h55AA_55AA, 1'b1);
        serve(2, 32'h9999_9999, 1, 2'b10);
        // Flush on the response cycle of a port 0 read.
        drive(0, 32'h0000_0040, 4'b1000, 4'h0, 32'h0);
        push(0, 32'h0000_0040, 4'b1000, 4'h0, 32'h0, 1'b1);
        serve(2, 32'h3333_4444, 2, 2'b01);

        // Flush and a stray d_resp while idle do nothing.
        @(negedge clk);
        flush = 1'b1;
        bus.d_resp = 1'b1;
        bus.d_rdata = 32'hFEED_F00D;
        #1;
        chk("idle_r0_resp", 32'(bus.r0_resp), 32'd0);
        chk("idle_r1_resp", 32'(bus.r1_resp), 32'd0);
        chk("idle_r0_rdata", bus.r0_rdata, 32'h0);
        chk("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        bus.d_resp = 1'b0;
        bus.d_rdata = 32'h0;
        drive(0, 32'h0000_0100, 4'hF, 4'h0, 32'h0);
        push(0, 32'h0000_0100, 4'hF, 4'h0, 32'h0, 1'b0);
        serve(2, 32'h0BAD_CAFE, 0, 2'b01);

        // Watchdog: six-cycle response trips the error, which stays set.
        drive(0, 32'h0000_4000, 4'hF, 4'h0, 32'h0);
        push(0, 32'h0000_4000, 4'hF, 4'h0, 32'h0, 1'b0);
        serve(6, 32'hCAFE_0000, 0, 2'b01);
        chk("err_sticky_model", 32'(err_timeout), 32'd1);

        // Asynchronous reset mid-transaction, then a tie must go to port 0.
        drive(0, 32'h0000_5000, 4'hF, 4'h0, 32'h0);
        @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        err_m = 1'b0;
        drive(0, 32'h0, 4'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 32'h0000_A000, 4'hF, 4'h0, 32'h0);
        drive(1, 32'h0000_B000, 4'hF, 4'h0, 32'h0);
        push(0, 32'h0000_A000, 4'hF, 4'h0, 32'h0, 1'b0);
        push(1, 32'h0000_B000, 4'hF, 4'h0, 32'h0, 1'b0);
        serve(2, 32'h0101_0101, 0, 2'b01);
        serve(2, 32'h0202_0202, 0, 2'b10);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
